set_bit_serializer: RTL and testbench

- Sequential consumer of a lowest-set-bit priority detector.
- Accepts a WIDTH-bit vector through a valid/ready handshake.
- Emits every set bit as a one-hot beat, lowest index first, one beat per accepted output handshake, then returns to idle.
- Used wherever a request/flag vector must be serviced one bit at a time: interrupt pending registers, multi-request dispatch.

---
 rtl/set_bit_serializer.sv | 89 ++++++++
 tb/tb_set_bit_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_bit_serializer.sv
// Serialises a WIDTH-bit request vector into one-hot beats, lowest set bit first.
// An all-zero vector produces a single empty beat flagged by op_zero.
module set_bit_serializer #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] op_vec,
    output logic [IDX_W-1:0] op_idx,
    output logic             op_last,
    output logic             op_zero
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             zero_flag_reg;

    logic             emit;
    logic [WIDTH-1:0] low_bit;
    logic [IDX_W-1:0] low_idx;
    logic             single_bit;
    logic             last_beat;

    assign emit       = (state_reg == EMIT);
    assign low_bit    = rem_reg & (~rem_reg + WIDTH'(1));
    assign single_bit = (rem_reg != '0) && ((rem_reg & (rem_reg - WIDTH'(1))) == '0);
    assign last_beat  = single_bit || zero_flag_reg;

    // Index encoder: index bit gi is set when the lone low bit sits at a position with bit gi set.
    genvar gi, gj;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_idx
            logic [WIDTH-1:0] idx_mask;
            for (gj = 0; gj < WIDTH; gj++) begin : g_mask
                assign idx_mask[gj] = 1'((gj >> gi) & 1);
            end
            assign low_idx[gi] = |(low_bit & idx_mask);
        end
    endgenerate

    // Every output is a function of registers only, so a stalled beat cannot change.
    assign in_ready  = !emit;
    assign out_valid = emit;
    assign op_vec    = (emit && !zero_flag_reg) ? low_bit : '0;
    assign op_idx    = (emit && !zero_flag_reg) ? low_idx : '0;
    assign op_last   = emit && last_beat;
    assign op_zero   = emit && zero_flag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rem_reg       <= '0;
            zero_flag_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        rem_reg       <= inp_vec;
                        zero_flag_reg <= (inp_vec == '0);
                        state_reg     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (last_beat) begin
                            state_reg     <= IDLE;
                            zero_flag_reg <= 1'b0;
                            rem_reg       <= '0;
                        end else begin
                            rem_reg <= rem_reg & ~low_bit;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_bit_serializer.sv
// Randomised self-checking bench for set_bit_serializer against a list-of-set-bits model.
module tb_set_bit_serializer;

    localparam int WIDTH = 4;
    localparam int IDX_W = $clog2(WIDTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] inp_vec = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] op_vec;
    logic [IDX_W-1:0] op_idx;
    logic             op_last;
    logic             op_zero;

    int tests = 0;
    int fails = 0;

    // Observed accepted beats, expected beats and the backpressure pattern
    logic [WIDTH-1:0] obs_vec[$];
    int               obs_idx[$];
    logic             obs_last[$];
    logic             obs_zero[$];
    logic [WIDTH-1:0] exp_vec[$];
    int               exp_idx[$];
    int               pat[$];
    int               cyc_count;

    set_bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .inp_vec(inp_vec),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_vec(op_vec), .op_idx(op_idx), .op_last(op_last), .op_zero(op_zero)
    );

    always #5 clk = ~clk;

    // Reference: the beats are simply the set bits of the vector in ascending order.
    function automatic void build_model(input logic [WIDTH-1:0] v);
        exp_vec.delete();
        exp_idx.delete();
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                exp_vec.push_back(WIDTH'(1) << i);
                exp_idx.push_back(i);
            end
        end
        if (v == 0) begin
            exp_vec.push_back('0);
            exp_idx.push_back(0);
        end
    endfunction

    // Presents v, then records accepted beats. mode 0: ready high, 1: random, 2: pat[]
    task automatic collect(input logic [WIDTH-1:0] v, input int mode,
                           output int timeout, output int hold_viol);
        logic             pend;
        logic [WIDTH-1:0] p_vec;
        logic [IDX_W-1:0] p_idx;
        logic             p_last, p_zero, r, done;
        int               n;
        obs_vec.delete(); obs_idx.delete(); obs_last.delete(); obs_zero.delete();
        timeout = 0; hold_viol = 0; cyc_count = 0; pend = 0; done = 0;
        p_vec = '0; p_idx = '0; p_last = 0; p_zero = 0;
        in_valid = 1'b1;
        inp_vec  = v;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeout = 1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            case (mode)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: r = (cyc_count < pat.size()) ? (pat[cyc_count] != 0) : 1'b1;
            endcase
            if (out_valid) begin
                if (pend && (op_vec !== p_vec || op_idx !== p_idx ||
                             op_last !== p_last || op_zero !== p_zero))
                    hold_viol++;
                p_vec = op_vec; p_idx = op_idx; p_last = op_last; p_zero = op_zero;
                cyc_count++;
                if (r) begin
                    obs_vec.push_back(op_vec);
                    obs_idx.push_back(int'(op_idx));
                    obs_last.push_back(op_last);
                    obs_zero.push_back(op_zero);
                    if (op_last) done = 1;
                end
                pend = !r;
            end
            out_ready = r;
            @(posedge clk);
        end
        if (!done) timeout = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_vec !== '0 ||
            op_idx !== '0 || op_last !== 1'b0 || op_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b vec=%b idx=%0d last=%b zero=%b, want 1 0 0000 0 0 0",
                     in_ready, out_valid, op_vec, op_idx, op_last, op_zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_idle: got vld=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_vector(input string name, input logic [WIDTH-1:0] v, input int mode,
                               input int exp_cycles);
        int to, hv, cnt;
        build_model(v);
        collect(v, mode, to, hv);
        tests++;
        if (to != 0) begin
            fails++;
            $display("FAIL %s_timeout: vector %b got no final beat, want completion", name, v);
        end
        tests++;
        if (obs_vec.size() != exp_vec.size()) begin
            fails++;
            $display("FAIL %s_count: got %0d beats, want %0d", name, obs_vec.size(), exp_vec.size());
        end
        cnt = (obs_vec.size() < exp_vec.size()) ? obs_vec.size() : exp_vec.size();
        for (int i = 0; i < cnt; i++) begin
            tests++;
            if (obs_vec[i] !== exp_vec[i] || obs_idx[i] != exp_idx[i] ||
                obs_last[i] !== (i == exp_vec.size() - 1) || obs_zero[i] !== (v == 0)) begin
                fails++;
                $display("FAIL %s_beat%0d: got vec=%b idx=%0d last=%b zero=%b, want vec=%b idx=%0d last=%b zero=%b",
                         name, i, obs_vec[i], obs_idx[i], obs_last[i], obs_zero[i],
                         exp_vec[i], exp_idx[i], (i == exp_vec.size() - 1), (v == 0));
            end
        end
        tests++;
        if (hv != 0) begin
            fails++;
            $display("FAIL %s_hold: got %0d beat changes under backpressure, want 0", name, hv);
        end
        if (exp_cycles > 0) begin
            tests++;
            if (cyc_count != exp_cycles) begin
                fails++;
                $display("FAIL %s_cycles: got %0d valid cycles, want %0d", name, cyc_count, exp_cycles);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_after: got rdy=%b vld=%b, want 1 0", name, in_ready, out_valid);
        end
        $display("[TB] %s vec=%b beats=%0d cycles=%0d", name, v, obs_vec.size(), cyc_count);
    endtask

    task automatic test_backpressure();
        pat = '{1, 0, 0, 1, 0, 1, 1};
        test_vector("backpressure", 4'b1111, 2, 7);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; inp_vec = 4'b0110; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || op_vec !== 4'b0010) begin
            fails++;
            $display("FAIL midrst_first: got vld=%b vec=%b, want 1 0010", out_valid, op_vec);
        end
        @(posedge clk);
        #2;
        tests++;
        if (op_vec !== 4'b0100) begin
            fails++;
            $display("FAIL midrst_pending: got vec=%b, want 0100", op_vec);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_vec !== '0 || op_last !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async: got vld=%b rdy=%b vec=%b last=%b, want 0 1 0000 0",
                     out_valid, in_ready, op_vec, op_last);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL midrst_after%0d: got vld=%b rdy=%b, want 0 1", i, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] want_vec[4];
        logic             want_vld[4];
        logic             want_last[4];
        want_vec  = '{4'b0100, 4'b1000, 4'b0000, 4'b0001};
        want_vld  = '{1'b1, 1'b1, 1'b0, 1'b1};
        want_last = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        in_valid = 1'b1; inp_vec = 4'b1100; out_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inp_vec = 4'b0001;
            tests++;
            if (out_valid !== want_vld[i] || op_vec !== want_vec[i] ||
                op_last !== want_last[i] || in_ready !== !want_vld[i]) begin
                fails++;
                $display("FAIL b2b_cycle%0d: got vld=%b vec=%b last=%b rdy=%b, want %b %b %b %b",
                         i, out_valid, op_vec, op_last, in_ready,
                         want_vld[i], want_vec[i], want_last[i], !want_vld[i]);
            end
            if (i == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got vld=%b, want 0", out_valid);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 16; v++) begin
            test_vector("sweep", 4'(v), 1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_vector("basic", 4'b1011, 0, 3);
        test_vector("zero", 4'b0000, 0, 1);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
